line_fetch_sched: RTL and testbench
===================================

LINE_FETCH_SCHED -- requirements
Module: line_fetch_sched

Interface
REQ-001 Parameter H_ACTIVE, default 640, SHALL be the number of active pixels per line.
REQ-002 Parameter H_TOTAL, default 800, SHALL be the number of pixel clocks per line.
REQ-003 Parameter V_ACTIVE, default 480, SHALL be the number of active lines per frame.
REQ-004 Parameter V_TOTAL, default 525, SHALL be the number of lines per frame.
REQ-005 pixel_clk  input  1  SHALL be the single clock; all state SHALL be updated on its rising edge.
REQ-006 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-007 counterX  input  10  SHALL be the horizontal position from the timing generator.
REQ-008 counterY  input  10  SHALL be the vertical position from the timing generator.
REQ-009 fetch_ack  input  1  SHALL be the memory-side acceptance of fetch_req.
REQ-010 fetch_done  input  1  SHALL be a one-cycle pulse from memory meaning the line is written to the buffer.
REQ-011 underflow_clr  input  1  SHALL clear the sticky underflow flag.
REQ-012 fetch_req  output  1  SHALL request a line fetch.
REQ-013 fetch_line  output  9  SHALL be the line number to fetch, and SHALL stay valid while fetch_req is high.
REQ-014 fetch_buf  output  1  SHALL be the ping-pong half to write, equal to fetch_line[0].
REQ-015 rd_buf  output  1  SHALL be the ping-pong half the display reads.
REQ-016 fetch_abort  output  1  SHALL pulse for one cycle when a fetch misses its deadline.
REQ-017 underflow  output  1  SHALL be a sticky flag meaning a deadline was missed.
REQ-018 late_count  output  8  SHALL count missed deadlines and saturate at 255.
REQ-019 frame_start  output  1  SHALL pulse for one cycle at the end of each frame.

Function
REQ-020 Trigger: at counterX==H_ACTIVE, the block SHALL compute the next display line ny.
- ny = counterY+1 when counterY < V_ACTIVE-1.
- ny = 0 when counterY == V_TOTAL-1.
- Otherwise there SHALL be no trigger.
REQ-021 The FSM SHALL have the states IDLE, REQ and BUSY; reset SHALL place it in IDLE.
REQ-022 IDLE->REQ on a trigger; in the same edge, fetch_line<=ny and fetch_req<=1.
REQ-023 In REQ, fetch_req SHALL stay high until the cycle fetch_ack==1 is sampled; the FSM SHALL then go to BUSY with fetch_req<=0.
REQ-024 BUSY->IDLE on fetch_done==1.
REQ-025 Deadline: at counterX==H_TOTAL-1 with the FSM in REQ or BUSY, the block SHALL:
- go to IDLE with fetch_req<=0;
- pulse fetch_abort;
- set underflow;
- increment late_count, saturating at 255.
REQ-026 If fetch_done arrives in the deadline cycle while in BUSY, done SHALL win: no abort, no underflow, no count.
REQ-027 If fetch_ack arrives in the deadline cycle while in REQ, the deadline SHALL win (abort).
REQ-028 fetch_ack and fetch_done in IDLE SHALL be ignored, and fetch_done in REQ SHALL be ignored.
REQ-029 rd_buf SHALL update at counterX==H_TOTAL-1 to ny[0], using the same ny rule as REQ-020; otherwise it SHALL hold.
REQ-030 frame_start SHALL be 1 for exactly the cycle after counterX==H_TOTAL-1 && counterY==V_TOTAL-1 is sampled.
REQ-031 If underflow is set and cleared in the same cycle, set SHALL win.
REQ-032 Otherwise underflow_clr SHALL clear underflow only; late_count SHALL clear only on reset.
REQ-033 All outputs SHALL be registered; trigger-to-fetch_req latency SHALL be 1 cycle.

Reset
REQ-034 While reset==0, the block SHALL force the following:
- FSM=IDLE;
- fetch_req=0 and fetch_line=0 (so fetch_buf=0);
- rd_buf=0, fetch_abort=0, underflow=0, late_count=0, frame_start=0.
REQ-035 Asserting reset mid-fetch SHALL drop fetch_req asynchronously without a fetch_abort pulse.
REQ-036 After reset release, the first trigger SHALL be the next qualifying counterX==H_ACTIVE.

Verification
REQ-037 The bench SHALL cover the following directed scenarios:
- Normal: counterY=10, counterX=640 -> next cycle fetch_req=1, fetch_line=11, fetch_buf=1; ack at X=650 -> req=0; done at X=700 -> IDLE, underflow=0.
- Frame wrap: counterY=524, X=640 -> fetch_line=0; at X=799 -> rd_buf=0 and frame_start pulses one cycle.
- Vblank: counterY=479..523, X=640 -> no fetch_req; at counterY=479, X=799 -> rd_buf unchanged.
- Deadline: no ack through X=799 -> fetch_abort pulse, underflow=1, late_count=1; repeated 300 lines -> late_count=255.
- Collision: done at X=799 in BUSY -> no abort; same-cycle underflow set and underflow_clr=1 -> underflow=1.
- Reset mid-BUSY (reset low at X=700) -> all outputs zero immediately; after release, operation resumes at the next X=640 of an active line.

Source files
------------

// File: rtl/line_fetch_sched.sv
// Schedules one line fetch per active scanline into a ping-pong line buffer,
// aborting fetches that miss the end-of-line deadline and tracking underflows.
module line_fetch_sched #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_TOTAL  = 800,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_TOTAL  = 525
) (
    input  logic       pixel_clk,
    input  logic       reset,
    input  logic [9:0] counterX,
    input  logic [9:0] counterY,
    input  logic       fetch_ack,
    input  logic       fetch_done,
    input  logic       underflow_clr,
    output logic       fetch_req,
    output logic [8:0] fetch_line,
    output logic       fetch_buf,
    output logic       rd_buf,
    output logic       fetch_abort,
    output logic       underflow,
    output logic [7:0] late_count,
    output logic       frame_start
);

    localparam int unsigned CW = 10;
    localparam int unsigned LW = 9;
    localparam int unsigned NW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        BUSY = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic           fetch_req_q, fetch_req_d;
    logic [LW-1:0]  fetch_line_q, fetch_line_d;
    logic           rd_buf_q, rd_buf_d;
    logic           fetch_abort_q, fetch_abort_d;
    logic           underflow_q, underflow_d;
    logic [NW-1:0]  late_count_q, late_count_d;
    logic           frame_start_q, frame_start_d;

    logic           last_line_c;
    logic           ny_valid_c;
    logic [LW-1:0]  ny_c;
    logic           trigger_c;
    logic           deadline_c;
    logic           miss_c;

    // Next display line: wraps to 0 after the last frame line, none during vblank.
    always_comb begin
        last_line_c = (counterY == CW'(V_TOTAL - 1));
        ny_valid_c  = (counterY < CW'(V_ACTIVE - 1)) || last_line_c;
        ny_c        = last_line_c ? '0 : LW'(counterY + CW'(1));
        trigger_c   = (counterX == CW'(H_ACTIVE)) && ny_valid_c;
        deadline_c  = (counterX == CW'(H_TOTAL - 1));
    end

    // Fetch handshake FSM plus deadline bookkeeping.
    always_comb begin
        state_d       = state_q;
        fetch_req_d   = fetch_req_q;
        fetch_line_d  = fetch_line_q;
        rd_buf_d      = rd_buf_q;
        fetch_abort_d = 1'b0;
        underflow_d   = underflow_q;
        late_count_d  = late_count_q;
        frame_start_d = deadline_c && last_line_c;
        miss_c        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (trigger_c) begin
                    state_d      = REQ;
                    fetch_req_d  = 1'b1;
                    fetch_line_d = ny_c;
                end
            end
            REQ: begin
                // A same-cycle ack cannot rescue a request that hit the deadline.
                if (deadline_c) begin
                    miss_c = 1'b1;
                end else if (fetch_ack) begin
                    state_d     = BUSY;
                    fetch_req_d = 1'b0;
                end
            end
            BUSY: begin
                if (fetch_done) begin
                    state_d = IDLE;
                end else if (deadline_c) begin
                    miss_c = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                fetch_req_d = 1'b0;
            end
        endcase

        if (miss_c) begin
            state_d       = IDLE;
            fetch_req_d   = 1'b0;
            fetch_abort_d = 1'b1;
            if (late_count_q != '1) begin
                late_count_d = late_count_q + NW'(1);
            end
        end

        if (miss_c) begin
            underflow_d = 1'b1;
        end else if (underflow_clr) begin
            underflow_d = 1'b0;
        end

        if (deadline_c && ny_valid_c) begin
            rd_buf_d = ny_c[0];
        end
    end

    always_ff @(posedge pixel_clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            fetch_req_q   <= 1'b0;
            fetch_line_q  <= '0;
            rd_buf_q      <= 1'b0;
            fetch_abort_q <= 1'b0;
            underflow_q   <= 1'b0;
            late_count_q  <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_req_q   <= fetch_req_d;
            fetch_line_q  <= fetch_line_d;
            rd_buf_q      <= rd_buf_d;
            fetch_abort_q <= fetch_abort_d;
            underflow_q   <= underflow_d;
            late_count_q  <= late_count_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign fetch_req   = fetch_req_q;
    assign fetch_line  = fetch_line_q;
    assign fetch_buf   = fetch_line_q[0];
    assign rd_buf      = rd_buf_q;
    assign fetch_abort = fetch_abort_q;
    assign underflow   = underflow_q;
    assign late_count  = late_count_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_line_fetch_sched.sv
// Directed bench for line_fetch_sched: handshake, frame wrap, vblank, deadline,
// collisions and asynchronous reset, with hand-computed expectations.
module tb_line_fetch_sched;

    logic       pixel_clk = 1'b0;
    logic       reset;
    logic [9:0] counterX;
    logic [9:0] counterY;
    logic       fetch_ack;
    logic       fetch_done;
    logic       underflow_clr;
    logic       fetch_req;
    logic [8:0] fetch_line;
    logic       fetch_buf;
    logic       rd_buf;
    logic       fetch_abort;
    logic       underflow;
    logic [7:0] late_count;
    logic       frame_start;

    int checks   = 0;
    int failures = 0;

    line_fetch_sched dut (
        .pixel_clk     (pixel_clk),
        .reset         (reset),
        .counterX      (counterX),
        .counterY      (counterY),
        .fetch_ack     (fetch_ack),
        .fetch_done    (fetch_done),
        .underflow_clr (underflow_clr),
        .fetch_req     (fetch_req),
        .fetch_line    (fetch_line),
        .fetch_buf     (fetch_buf),
        .rd_buf        (rd_buf),
        .fetch_abort   (fetch_abort),
        .underflow     (underflow),
        .late_count    (late_count),
        .frame_start   (frame_start)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, clock it, and settle past the edge.
    task automatic tick(input logic [9:0] x, input logic [9:0] y,
                        input logic ack, input logic done, input logic clr);
        counterX      = x;
        counterY      = y;
        fetch_ack     = ack;
        fetch_done    = done;
        underflow_clr = clr;
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"},   32'(fetch_req),   32'd0);
        chk({tag, "_line"},  32'(fetch_line),  32'd0);
        chk({tag, "_buf"},   32'(fetch_buf),   32'd0);
        chk({tag, "_rdbuf"}, 32'(rd_buf),      32'd0);
        chk({tag, "_abort"}, 32'(fetch_abort), 32'd0);
        chk({tag, "_uflow"}, 32'(underflow),   32'd0);
        chk({tag, "_late"},  32'(late_count),  32'd0);
        chk({tag, "_fs"},    32'(frame_start), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        counterX = '0; counterY = '0;
        fetch_ack = 1'b0; fetch_done = 1'b0; underflow_clr = 1'b0;
        tick(10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
        tick(10'd1, 10'd0, 1'b0, 1'b0, 1'b0);
        chk_all_zero("reset");
        reset = 1'b1;

        // Normal fetch of line 11
        tick(10'd639, 10'd10, 1'b0, 1'b0, 1'b0);
        chk("pre_trig_req", 32'(fetch_req), 32'd0);
        tick(10'd640, 10'd10, 1'b0, 1'b0, 1'b0);
        chk("norm_req",  32'(fetch_req),  32'd1);
        chk("norm_line", 32'(fetch_line), 32'd11);
        chk("norm_buf",  32'(fetch_buf),  32'd1);
        tick(10'd645, 10'd10, 1'b0, 1'b0, 1'b0);
        chk("norm_req_hold", 32'(fetch_req), 32'd1);
        tick(10'd650, 10'd10, 1'b1, 1'b0, 1'b0);
        chk("norm_ack_req", 32'(fetch_req), 32'd0);
        tick(10'd700, 10'd10, 1'b0, 1'b1, 1'b0);
        chk("norm_uflow", 32'(underflow), 32'd0);
        tick(10'd799, 10'd10, 1'b0, 1'b0, 1'b0);
        chk("norm_abort", 32'(fetch_abort), 32'd0);
        chk("norm_rdbuf", 32'(rd_buf),      32'd1);
        chk("norm_fs",    32'(frame_start), 32'd0);

        // Frame wrap: last line fetches line 0
        tick(10'd640, 10'd524, 1'b0, 1'b0, 1'b0);
        chk("wrap_req",  32'(fetch_req),  32'd1);
        chk("wrap_line", 32'(fetch_line), 32'd0);
        chk("wrap_buf",  32'(fetch_buf),  32'd0);
        tick(10'd650, 10'd524, 1'b1, 1'b0, 1'b0);
        tick(10'd700, 10'd524, 1'b0, 1'b1, 1'b0);
        tick(10'd799, 10'd524, 1'b0, 1'b0, 1'b0);
        chk("wrap_rdbuf", 32'(rd_buf),      32'd0);
        chk("wrap_fs",    32'(frame_start), 32'd1);
        chk("wrap_abort", 32'(fetch_abort), 32'd0);
        tick(10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
        chk("wrap_fs_end", 32'(frame_start), 32'd0);

        // Last active line, then vblank
        tick(10'd640, 10'd478, 1'b0, 1'b0, 1'b0);
        chk("l479_line", 32'(fetch_line), 32'd479);
        tick(10'd650, 10'd478, 1'b1, 1'b0, 1'b0);
        tick(10'd700, 10'd478, 1'b0, 1'b1, 1'b0);
        tick(10'd799, 10'd478, 1'b0, 1'b0, 1'b0);
        chk("l479_rdbuf", 32'(rd_buf), 32'd1);
        for (int y = 479; y <= 523; y++) begin
            tick(10'd640, 10'(y), 1'b0, 1'b0, 1'b0);
            chk($sformatf("vblank_req_y%0d", y), 32'(fetch_req), 32'd0);
        end
        chk("vblank_line", 32'(fetch_line), 32'd479);
        tick(10'd799, 10'd479, 1'b0, 1'b0, 1'b0);
        chk("vblank_rdbuf", 32'(rd_buf),      32'd1);
        chk("vblank_abort", 32'(fetch_abort), 32'd0);

        // Deadline miss in REQ
        tick(10'd640, 10'd20, 1'b0, 1'b0, 1'b0);
        chk("dl_line", 32'(fetch_line), 32'd21);
        tick(10'd799, 10'd20, 1'b0, 1'b0, 1'b0);
        chk("dl_abort", 32'(fetch_abort), 32'd1);
        chk("dl_req",   32'(fetch_req),   32'd0);
        chk("dl_uflow", 32'(underflow),   32'd1);
        chk("dl_late",  32'(late_count),  32'd1);
        tick(10'd0, 10'd21, 1'b0, 1'b0, 1'b0);
        chk("dl_abort_end", 32'(fetch_abort), 32'd0);
        chk("dl_uflow_sticky", 32'(underflow), 32'd1);

        // Ack on the deadline cycle loses
        tick(10'd640, 10'd30, 1'b0, 1'b0, 1'b0);
        tick(10'd799, 10'd30, 1'b1, 1'b0, 1'b0);
        chk("ackdl_abort", 32'(fetch_abort), 32'd1);
        chk("ackdl_late",  32'(late_count),  32'd2);
        tick(10'd0, 10'd31, 1'b0, 1'b0, 1'b0);

        // Deadline miss in BUSY
        tick(10'd640, 10'd40, 1'b0, 1'b0, 1'b0);
        tick(10'd650, 10'd40, 1'b1, 1'b0, 1'b0);
        tick(10'd799, 10'd40, 1'b0, 1'b0, 1'b0);
        chk("busydl_abort", 32'(fetch_abort), 32'd1);
        chk("busydl_late",  32'(late_count),  32'd3);

        // 297 more misses, 300 total -> saturated at 255
        for (int i = 0; i < 297; i++) begin
            tick(10'd640, 10'd20, 1'b0, 1'b0, 1'b0);
            tick(10'd799, 10'd20, 1'b0, 1'b0, 1'b0);
        end
        chk("sat_late", 32'(late_count), 32'd255);
        tick(10'd5, 10'd21, 1'b0, 1'b0, 1'b1);
        chk("clr_uflow", 32'(underflow),  32'd0);
        chk("clr_late",  32'(late_count), 32'd255);
        tick(10'd6, 10'd21, 1'b0, 1'b0, 1'b0);

        // Done on the deadline cycle wins
        tick(10'd640, 10'd50, 1'b0, 1'b0, 1'b0);
        tick(10'd650, 10'd50, 1'b1, 1'b0, 1'b0);
        tick(10'd799, 10'd50, 1'b0, 1'b1, 1'b0);
        chk("coll_abort", 32'(fetch_abort), 32'd0);
        chk("coll_uflow", 32'(underflow),   32'd0);
        chk("coll_late",  32'(late_count),  32'd255);

        // Underflow set beats same-cycle clear
        tick(10'd640, 10'd60, 1'b0, 1'b0, 1'b0);
        tick(10'd799, 10'd60, 1'b0, 1'b0, 1'b1);
        chk("setclr_uflow", 32'(underflow),   32'd1);
        chk("setclr_abort", 32'(fetch_abort), 32'd1);

        // Done in REQ is ignored
        tick(10'd640, 10'd70, 1'b0, 1'b0, 1'b0);
        tick(10'd700, 10'd70, 1'b0, 1'b1, 1'b0);
        chk("reqdone_req", 32'(fetch_req), 32'd1);
        tick(10'd710, 10'd70, 1'b1, 1'b0, 1'b0);
        chk("reqdone_ack", 32'(fetch_req), 32'd0);
        tick(10'd720, 10'd70, 1'b0, 1'b1, 1'b0);
        tick(10'd799, 10'd70, 1'b0, 1'b0, 1'b0);
        chk("reqdone_abort", 32'(fetch_abort), 32'd0);
        chk("reqdone_rdbuf", 32'(rd_buf),      32'd1);

        // Asynchronous reset while requesting
        tick(10'd640, 10'd80, 1'b0, 1'b0, 1'b0);
        chk("rstreq_req_pre", 32'(fetch_req), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("rstreq");
        tick(10'd650, 10'd80, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        tick(10'd799, 10'd80, 1'b0, 1'b0, 1'b0);
        chk("rstreq_post_abort", 32'(fetch_abort), 32'd0);
        tick(10'd640, 10'd81, 1'b0, 1'b0, 1'b0);
        chk("resume1_req",  32'(fetch_req),  32'd1);
        chk("resume1_line", 32'(fetch_line), 32'd82);

        // Asynchronous reset in BUSY at X=700
        tick(10'd650, 10'd81, 1'b1, 1'b0, 1'b0);
        counterX = 10'd700;
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("rstbusy");
        tick(10'd701, 10'd81, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        tick(10'd799, 10'd81, 1'b0, 1'b0, 1'b0);
        chk("rstbusy_abort", 32'(fetch_abort), 32'd0);
        chk("rstbusy_uflow", 32'(underflow),   32'd0);
        tick(10'd640, 10'd500, 1'b0, 1'b0, 1'b0);
        chk("rstbusy_vblank_req", 32'(fetch_req), 32'd0);
        tick(10'd640, 10'd90, 1'b0, 1'b0, 1'b0);
        chk("resume2_req",  32'(fetch_req),  32'd1);
        chk("resume2_line", 32'(fetch_line), 32'd91);
        chk("resume2_buf",  32'(fetch_buf),  32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
